compression_decompression_dict: RTL and testbench
=================================================

Name: compression_decompression_dict

Overview:
- Parametrised successor to the fixed 80-bit/8-bit compression_decompression engine.
- Maintains a DEPTH-entry dictionary of DATA_W-bit words.
- COMPRESS: maps a word to its dictionary index, inserting the word on a miss.
- DECOMPRESS: maps an index back to its word.
- Adds a valid/ready command interface, a held response handshake, a CLEAR command and occupancy status. Sits between the stimulus/driver side and the scoreboard-visible response bus.

Parameters:
- DATA_W, 80: width of uncompressed word.
- DEPTH, 16: dictionary entries; must satisfy 1 <= DEPTH <= 2**IDX_W.
- IDX_W, 8: width of compressed index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (IDLE only).
- command  in  2  00 NOP, 01 COMPRESS, 10 DECOMPRESS, 11 CLEAR.
- data_in  in  DATA_W  word to compress; sampled at acceptance.
- compressed_in  in  IDX_W  index to decompress; sampled at acceptance.
- rsp_valid  out  1  response outputs valid.
- rsp_ready  in  1  consumer accepts response.
- compressed_out  out  IDX_W  index result.
- decompressed_out  out  DATA_W  word result.
- response  out  2  00 CLEAR_DONE, 01 COMP_OK, 10 DECOMP_OK, 11 ERROR.
- dict_count  out  IDX_W+1  valid entries.
- dict_full  out  1  dict_count == DEPTH.

Behaviour:
- Reset (async, any state): FSM to IDLE; dict_count=0; cmd_ready=1; rsp_valid=0; compressed_out=0; decompressed_out=0; response=00; dict_full=0. Dictionary RAM contents are not cleared and need not be. Any in-flight command is dropped with no response.
- Acceptance: cmd_valid && cmd_ready at a rising edge. data_in, compressed_in and command are latched; inputs are ignored afterwards.
- FSM states: IDLE, SEARCH, READ, RESP.
- IDLE, NOP: accepted; stays IDLE; no response.
- IDLE, CLEAR: goes to RESP.
  - dict_count <= 0.
  - response=00, compressed_out=0, decompressed_out=0.
  - Latency 1: rsp_valid high the cycle after acceptance.
- IDLE, COMPRESS: goes to SEARCH with ptr=0.
  - Each SEARCH cycle compares entry[ptr] with the latched word; only entries with ptr < dict_count are valid.
  - Hit at h: goes to RESP with compressed_out=h, response=01. Latency h+2.
  - Miss after all dict_count entries (one SEARCH cycle minimum when dict_count=0), not full: entry[dict_count] <= word; compressed_out=old dict_count; dict_count+1; response=01. Latency max(dict_count,1)+1.
  - Miss and full: response=11, compressed_out=0, dictionary unchanged.
  - decompressed_out is set to 0 on every compress response.
- IDLE, DECOMPRESS: goes to READ (1 cycle), then RESP.
  - compressed_in < dict_count: decompressed_out=entry[idx], response=10.
  - Otherwise: decompressed_out=0, response=11.
  - compressed_out=0 in both cases. Latency 2.
- RESP:
  - rsp_valid=1; all response outputs are held stable until rsp_ready=1 at an edge.
  - On that edge the FSM returns to IDLE and rsp_valid drops.
  - Outputs keep their last values while rsp_valid=0.
  - rsp_ready already high on RESP entry: handshake completes on the first RESP edge.
- cmd_ready=0 in SEARCH/READ/RESP; a command held valid during that time waits and is not lost.
- dict_count/dict_full update on the same edge that enters RESP.
- Duplicate compress of the same word never inserts twice.

Test Plan:
- Reset, then COMPRESS 80'h1234 -> 2 cycles later rsp_valid=1, response=01, compressed_out=0, dict_count=1.
- COMPRESS 80'hA, 80'hB, 80'hC, then 80'hB -> indices 0, 1, 2, then 1; latency of the last is 3 cycles; dict_count stays 3.
- After the previous case, DECOMPRESS 2 -> decompressed_out=80'hC, response=10, latency 2; DECOMPRESS 5 -> response=11, decompressed_out=0.
- DEPTH=4: compress 4 distinct words, then a 5th new word -> response=11, dict_full=1, dict_count=4; then CLEAR -> response=00, dict_count=0.
- Hold rsp_ready=0 for 5 cycles with cmd_valid high -> outputs stable, cmd_ready=0, the next command is accepted only after the handshake.
- Assert reset during SEARCH of a 10-entry dictionary -> rsp_valid=0 immediately, dict_count=0; a subsequent DECOMPRESS 0 returns 11.

Source files
------------

// File: rtl/compression_decompression_dict.sv
// Dictionary word <-> index translator: COMPRESS searches/inserts, DECOMPRESS reads back,
// with a valid/ready command port and a response held until rsp_ready.
module compression_decompression_dict #(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        command,
  input  logic [DATA_W-1:0] data_in,
  input  logic [IDX_W-1:0]  compressed_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDX_W-1:0]  compressed_out,
  output logic [DATA_W-1:0] decompressed_out,
  output logic [1:0]        response,
  output logic [IDX_W:0]    dict_count,
  output logic              dict_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

  localparam logic [1:0] CMD_COMP   = 2'b01;
  localparam logic [1:0] CMD_DECOMP = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [1:0] RSP_CLEAR  = 2'b00;
  localparam logic [1:0] RSP_COMP   = 2'b01;
  localparam logic [1:0] RSP_DECOMP = 2'b10;
  localparam logic [1:0] RSP_ERR    = 2'b11;

  typedef enum logic [1:0] {IDLE, SEARCH, READ, RESP} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   word_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W:0]      ptr, ptr_n;
  logic [IDX_W:0]      count_n;
  logic [IDX_W-1:0]    cout_n;
  logic [DATA_W-1:0]   dout_n;
  logic [1:0]          resp_n;
  logic                wr_en;
  logic                accept;
  logic                hit;
  logic                last;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dict_full = (dict_count == DEPTH_C);
  assign accept    = cmd_valid && cmd_ready;

  // Only entries below dict_count are meaningful; stale RAM contents beyond it are ignored.
  assign hit  = (ptr < dict_count) && (mem[ptr[AW-1:0]] == word_q);
  assign last = (ptr + ONE) >= dict_count;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    count_n = dict_count;
    cout_n  = compressed_out;
    dout_n  = decompressed_out;
    resp_n  = response;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (command)
            CMD_COMP: begin
              state_n = SEARCH;
              ptr_n   = '0;
            end
            CMD_DECOMP: state_n = READ;
            CMD_CLEAR: begin
              state_n = RESP;
              count_n = '0;
              resp_n  = RSP_CLEAR;
              cout_n  = '0;
              dout_n  = '0;
            end
            default: ;
          endcase
        end
      end
      SEARCH: begin
        if (hit) begin
          state_n = RESP;
          cout_n  = ptr[IDX_W-1:0];
          dout_n  = '0;
          resp_n  = RSP_COMP;
        end else if (last) begin
          state_n = RESP;
          dout_n  = '0;
          if (dict_count < DEPTH_C) begin
            wr_en   = 1'b1;
            cout_n  = dict_count[IDX_W-1:0];
            count_n = dict_count + ONE;
            resp_n  = RSP_COMP;
          end else begin
            cout_n  = '0;
            resp_n  = RSP_ERR;
          end
        end else begin
          ptr_n = ptr + ONE;
        end
      end
      READ: begin
        state_n = RESP;
        cout_n  = '0;
        if ({1'b0, idx_q} < dict_count) begin
          dout_n = mem[idx_q[AW-1:0]];
          resp_n = RSP_DECOMP;
        end else begin
          dout_n = '0;
          resp_n = RSP_ERR;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr              <= '0;
      dict_count       <= '0;
      compressed_out   <= '0;
      decompressed_out <= '0;
      response         <= RSP_CLEAR;
      word_q           <= '0;
      idx_q            <= '0;
    end else begin
      ptr              <= ptr_n;
      dict_count       <= count_n;
      compressed_out   <= cout_n;
      decompressed_out <= dout_n;
      response         <= resp_n;
      if (accept) begin
        word_q <= data_in;
        idx_q  <= compressed_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[dict_count[AW-1:0]] <= word_q;
  end

endmodule

// File: tb/tb_compression_decompression_dict.sv
// Randomized bench for compression_decompression_dict against a queue-based dictionary model.
module tb_compression_decompression_dict;

  localparam int DATA_W = 80;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 8;

  localparam logic [1:0] NOP    = 2'b00;
  localparam logic [1:0] COMP   = 2'b01;
  localparam logic [1:0] DECOMP = 2'b10;
  localparam logic [1:0] CLEAR  = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        command;
  logic [DATA_W-1:0] data_in;
  logic [IDX_W-1:0]  compressed_in;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDX_W-1:0]  compressed_out;
  logic [DATA_W-1:0] decompressed_out;
  logic [1:0]        response;
  logic [IDX_W:0]    dict_count;
  logic              dict_full;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model[$];

  always #5 clk = ~clk;

  compression_decompression_dict #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .command(command), .data_in(data_in), .compressed_in(compressed_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .compressed_out(compressed_out),
    .decompressed_out(decompressed_out), .response(response),
    .dict_count(dict_count), .dict_full(dict_full)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Dictionary semantics: index = position of first occurrence; misses append while room remains.
  task automatic model_exec(input logic [1:0] cmd, input logic [DATA_W-1:0] word, input int idx,
                            output logic [1:0] er, output int ec,
                            output logic [DATA_W-1:0] ed, output int el);
    er = 2'b00; ec = 0; ed = '0; el = 0;
    case (cmd)
      COMP: begin
        int found = -1;
        foreach (model[i]) if (found < 0 && model[i] == word) found = i;
        if (found >= 0) begin
          er = 2'b01; ec = found; el = found + 2;
        end else begin
          el = ((model.size() > 1) ? model.size() : 1) + 1;
          if (model.size() < DEPTH) begin
            er = 2'b01; ec = model.size(); model.push_back(word);
          end else begin
            er = 2'b11;
          end
        end
      end
      DECOMP: begin
        el = 2;
        if (idx < model.size()) begin er = 2'b10; ed = model[idx]; end
        else er = 2'b11;
      end
      CLEAR: begin
        el = 1;
        model.delete();
      end
      default: el = 0;
    endcase
  endtask

  task automatic send(input logic [1:0] cmd, input logic [DATA_W-1:0] word, input int idx);
    int w = 0;
    while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1; command = cmd; data_in = word; compressed_in = idx[IDX_W-1:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] er, input int ec,
                            input logic [DATA_W-1:0] ed);
    check({tag, "_response"}, response, er);
    check({tag, "_compressed_out"}, compressed_out, ec);
    check({tag, "_decompressed_out"}, decompressed_out, ed);
    check({tag, "_dict_count"}, dict_count, model.size());
    check({tag, "_dict_full"}, dict_full, model.size() == DEPTH);
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] er, input int ec,
                          input logic [DATA_W-1:0] ed, input int el, input int hold);
    int cyc = 1;
    while (!rsp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_latency"}, cyc, el);
    check_outs(tag, er, ec, ed);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_held_valid"}, rsp_valid, 1);
      check({tag, "_held_cmd_ready"}, cmd_ready, 0);
      check_outs({tag, "_held"}, er, ec, ed);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_released"}, rsp_valid, 0);
    check({tag, "_idle_ready"}, cmd_ready, 1);
    check({tag, "_kept_response"}, response, er);
  endtask

  task automatic run_op(input logic [1:0] cmd, input logic [DATA_W-1:0] word, input int idx,
                        input int hold, input bit early);
    logic [1:0] er; int ec; int el; logic [DATA_W-1:0] ed;
    string tag;
    tag = (cmd == COMP) ? "compress" : (cmd == DECOMP) ? "decompress" :
          (cmd == CLEAR) ? "clear" : "nop";
    if (early) rsp_ready = 1'b1;
    model_exec(cmd, word, idx, er, ec, ed, el);
    send(cmd, word, idx);
    if (cmd == NOP) begin
      rsp_ready = 1'b0;
      check("nop_no_rsp", rsp_valid, 0);
      check("nop_ready", cmd_ready, 1);
    end else begin
      wait_rsp(tag, er, ec, ed, el, early ? 0 : hold);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] er; int ec; int el; logic [DATA_W-1:0] ed;
    reset = 1'b1; cmd_valid = 1'b0; command = NOP; data_in = '0;
    compressed_in = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_response", response, 0);
    check("reset_compressed_out", compressed_out, 0);
    check("reset_decompressed_out", decompressed_out, 0);
    check("reset_dict_count", dict_count, 0);
    check("reset_dict_full", dict_full, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(COMP, 80'h1234, 0, 0, 0);
    run_op(CLEAR, '0, 0, 1, 0);
    run_op(COMP, 80'hA, 0, 0, 0);
    run_op(COMP, 80'hB, 0, 2, 0);
    run_op(COMP, 80'hC, 0, 0, 1);
    run_op(COMP, 80'hB, 0, 0, 0);
    run_op(DECOMP, '0, 2, 0, 0);
    run_op(DECOMP, '0, 5, 0, 0);

    // Response stalled 5 cycles with the next command already waiting on cmd_valid.
    model_exec(COMP, 80'hA, 0, er, ec, ed, el);
    send(COMP, 80'hA, 0);
    cmd_valid = 1'b1; command = DECOMP; compressed_in = 8'd0;
    wait_rsp("stall", er, ec, ed, el, 5);
    model_exec(DECOMP, '0, 0, er, ec, ed, el);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("stall_next_accepted", cmd_ready, 0);
    wait_rsp("stall_next", er, ec, ed, el, 0);

    run_op(CLEAR, '0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) run_op(COMP, DATA_W'(32'h5000 + i), 0, 0, 0);
    run_op(COMP, 80'h6000, 0, 1, 0);
    run_op(COMP, 80'h500F, 0, 0, 0);
    run_op(DECOMP, '0, DEPTH - 1, 0, 0);
    run_op(CLEAR, '0, 0, 0, 1);

    for (int i = 0; i < 10; i++) run_op(COMP, DATA_W'(32'h100 + i), 0, 0, 0);
    send(COMP, 80'h999, 0);
    repeat (4) @(posedge clk);
    #1;
    check("search_busy", cmd_ready, 0);
    reset = 1'b1;
    #1;
    check("midreset_rsp_valid", rsp_valid, 0);
    check("midreset_dict_count", dict_count, 0);
    check("midreset_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    model.delete();
    run_op(DECOMP, '0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int r;
      logic [1:0] cmd;
      r = $urandom_range(0, 19);
      cmd = (r == 0) ? CLEAR : (r < 3) ? NOP : (r < 13) ? COMP : DECOMP;
      run_op(cmd, DATA_W'(32'hC000 + $urandom_range(0, 23)), $urandom_range(0, 19),
             $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
